// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and character helpers for the LCD value display.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_DDRAM_L1  = 8'h80;
    localparam logic [7:0] CMD_DDRAM_L2  = 8'hC0;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_CLR_WAIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHAR
    } state_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        WR_DONE
    } wr_phase_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = CMD_FUNC_8B2L;
            2'd1:    init_cmd = CMD_DISP_ON;
            2'd2:    init_cmd = CMD_ENTRY_INC;
            default: init_cmd = CMD_CLEAR;
        endcase
    endfunction

    // 0x37 + 10 lands on 'A', giving uppercase hex digits.
    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        hex_ascii = (d < 4'd10) ? ASCII_ZERO + {4'h0, d} : 8'h37 + {4'h0, d};
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one HD44780 byte write: setup with E low, E pulse, hold with E low, then a done pulse.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] byte_val,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic       done
);

    localparam int MAX_AB = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_C  = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int CW     = $clog2(MAX_C + 1);

    wr_phase_t     phase, phase_nxt;
    logic [CW-1:0] cnt;

    always_comb begin
        phase_nxt = phase;
        case (phase)
            WR_IDLE:  if (start) phase_nxt = WR_SETUP;
            WR_SETUP: if (cnt == CW'(SETUP_CYC - 1)) phase_nxt = WR_PULSE;
            WR_PULSE: if (cnt == CW'(PULSE_CYC - 1)) phase_nxt = WR_HOLD;
            WR_HOLD:  if (cnt == CW'(HOLD_CYC - 1)) phase_nxt = WR_DONE;
            WR_DONE:  phase_nxt = WR_IDLE;
            default:  phase_nxt = WR_IDLE;
        endcase
    end

    // E is registered from the next phase so it toggles exactly on phase boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= WR_IDLE;
            cnt      <= '0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
        end else begin
            phase <= phase_nxt;
            if (phase_nxt != phase || phase == WR_IDLE || phase == WR_DONE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (phase == WR_IDLE && start) begin
                lcd_data <= byte_val;
                lcd_rs   <= rs;
            end
            lcd_e <= (phase_nxt == WR_PULSE);
        end
    end

    assign done = (phase == WR_DONE);

endmodule

// File: rtl/lcd_value_display.sv
// HD44780 debug readout: init sequence, then renders each accepted value as binary or hex text.
module lcd_value_display
    import lcd_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2,
    parameter int CLR_WAIT  = 80000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              hex_mode,
    input  logic              line_sel,
    output logic              data_ready,
    output logic              init_done,
    output logic [7:0]        lcd_data,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e
);

    localparam int NHEX  = (DATA_W + 3) / 4;
    localparam int HEX_W = 4 * NHEX;
    localparam int DCW   = $clog2(HEX_W);
    localparam int WCW   = $clog2(CLR_WAIT + 1);

    state_t           state, state_nxt;
    logic [HEX_W-1:0] val_q;
    logic             hex_q, line_q;
    logic [DCW-1:0]   dcnt;
    logic [1:0]       idx;
    logic             sent;
    logic [WCW-1:0]   wcnt;
    logic             init_done_q;

    logic             start, wr_rs, wr_done, accept;
    logic [7:0]       wr_byte, digit;
    logic [HEX_W-1:0] val_sh;

    // Digit under dcnt: bit dcnt in binary mode, nibble dcnt in hex mode.
    always_comb begin
        val_sh = val_q >> {dcnt, 2'b00};
        digit  = hex_q ? hex_ascii(val_sh[3:0]) : (ASCII_ZERO | {7'h0, val_q[dcnt]});
    end

    // sent marks that the current byte has been handed to the writer; cleared on its done.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        wr_rs     = 1'b0;
        wr_byte   = init_cmd(idx);
        accept    = 1'b0;
        case (state)
            ST_INIT: begin
                start = !sent;
                if (wr_done && idx == 2'd3) state_nxt = ST_CLR_WAIT;
            end
            ST_CLR_WAIT: begin
                if (wcnt == WCW'(CLR_WAIT - 1)) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                accept = data_valid;
                if (data_valid) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                start   = !sent;
                wr_byte = line_q ? CMD_DDRAM_L2 : CMD_DDRAM_L1;
                if (wr_done) state_nxt = ST_CHAR;
            end
            ST_CHAR: begin
                start   = !sent;
                wr_rs   = 1'b1;
                wr_byte = digit;
                if (wr_done && dcnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_INIT;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q       <= '0;
            hex_q       <= 1'b0;
            line_q      <= 1'b0;
            dcnt        <= '0;
            idx         <= 2'd0;
            sent        <= 1'b0;
            wcnt        <= '0;
            init_done_q <= 1'b0;
        end else begin
            if (start)        sent <= 1'b1;
            else if (wr_done) sent <= 1'b0;

            if (state == ST_INIT && wr_done) idx <= idx + 2'd1;

            wcnt <= (state == ST_CLR_WAIT) ? wcnt + 1'b1 : '0;

            if (state_nxt == ST_IDLE) init_done_q <= 1'b1;

            if (accept) begin
                val_q  <= HEX_W'(data_in);
                hex_q  <= hex_mode;
                line_q <= line_sel;
                dcnt   <= hex_mode ? DCW'(NHEX - 1) : DCW'(DATA_W - 1);
            end else if (state == ST_CHAR && wr_done && dcnt != '0) begin
                dcnt <= dcnt - 1'b1;
            end
        end
    end

    lcd_byte_writer #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_writer (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rs       (wr_rs),
        .byte_val (wr_byte),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .done     (wr_done)
    );

    assign data_ready = (state == ST_IDLE);
    assign init_done  = init_done_q;
    assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_value_display.sv
// Directed bench for lcd_value_display: init sequence, render vectors, back-pressure and reset.
module tb_lcd_value_display;

    localparam int DATA_W = 10, SETUP = 1, PULSE = 2, HOLD = 1, CLRW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic              data_valid, hex_mode, line_sel;
    logic              data_ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]        lcd_data;

    lcd_value_display #(
        .DATA_W(DATA_W), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD), .CLR_WAIT(CLRW)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .hex_mode(hex_mode), .line_sel(line_sel), .data_ready(data_ready),
        .init_done(init_done), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_e(lcd_e)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] d;
        logic       hex;
        logic       line;
        logic [7:0] addr;
        string      s;
    } vec_t;

    vec_t       v[7];
    logic [8:0] q[$];
    int total = 0, bad = 0;
    int cyc = 0, acc_cnt = 0, hi_run = 0, max_hi = 0, bad_pw = 0, bad_stab = 0;
    int fall_cyc = 0, id_rise_cyc = 0;
    logic e_prev = 1'b0, id_prev = 1'b0;
    logic [8:0] rise_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (!rst) begin
            e_prev  <= 1'b0;
            id_prev <= 1'b0;
            hi_run  <= 0;
        end else begin
            if (lcd_e && !e_prev) begin
                q.push_back({lcd_rs, lcd_data});
                rise_val <= {lcd_rs, lcd_data};
            end
            if (!lcd_e && e_prev) begin
                if (hi_run != PULSE) bad_pw <= bad_pw + 1;
                if ({lcd_rs, lcd_data} != rise_val) bad_stab <= bad_stab + 1;
                fall_cyc <= cyc;
            end
            hi_run <= lcd_e ? hi_run + 1 : 0;
            if (lcd_e && hi_run + 1 > max_hi) max_hi <= hi_run + 1;
            if (init_done && !id_prev) id_rise_cyc <= cyc;
            if (data_valid && data_ready) acc_cnt <= acc_cnt + 1;
            e_prev  <= lcd_e;
            id_prev <= init_done;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        while (!data_ready && n < bound) begin tick(); n++; end
        chk("ready_timeout", int'(data_ready), 1);
    endtask

    task automatic wait_init(input int bound);
        int n = 0;
        while (!init_done && n < bound) begin tick(); n++; end
        chk("init_timeout", int'(init_done), 1);
    endtask

    task automatic run_vec(input int k, input bit toggle);
        int a0;
        wait_ready(300);
        q.delete();
        a0 = acc_cnt;
        data_in = v[k].d; hex_mode = v[k].hex; line_sel = v[k].line; data_valid = 1'b1;
        tick();
        data_valid = 1'b0; data_in = ~v[k].d; hex_mode = ~v[k].hex; line_sel = ~v[k].line;
        chk("ready_fall", int'(data_ready), 0);
        chk("lat_e0", int'(lcd_e), 0);
        tick();
        chk("lat_e1", int'(lcd_e), 0);
        tick();
        chk("lat_rise", int'(lcd_e), 1);
        if (toggle) begin
            repeat (20) begin
                tick();
                data_in = 10'($urandom); hex_mode = 1'($urandom); line_sel = 1'($urandom);
                data_valid = 1'b1;
            end
            data_valid = 1'b0;
        end
        wait_ready(400);
        chk($sformatf("v%0d_count", k), q.size(), v[k].s.len() + 1);
        chk($sformatf("v%0d_accepts", k), acc_cnt - a0, 1);
        if (q.size() > 0) chk($sformatf("v%0d_addr", k), int'(q[0]), int'({1'b0, v[k].addr}));
        for (int i = 0; i < v[k].s.len(); i++)
            if (i + 1 < q.size())
                chk($sformatf("v%0d_char%0d", k, i), int'(q[i+1]), int'({1'b1, v[k].s[i]}));
    endtask

    initial begin
        int a0, naddr, n;
        v[0] = '{10'b1010000011, 1'b0, 1'b0, 8'h80, "1010000011"};
        v[1] = '{10'h2AF,        1'b1, 1'b1, 8'hC0, "2AF"};
        v[2] = '{10'h3FF,        1'b0, 1'b1, 8'hC0, "1111111111"};
        v[3] = '{10'h000,        1'b1, 1'b0, 8'h80, "000"};
        v[4] = '{10'h1C5,        1'b1, 1'b0, 8'h80, "1C5"};
        v[5] = '{10'h0B4,        1'b1, 1'b1, 8'hC0, "0B4"};
        v[6] = '{10'h001,        0,    1'b0, 8'h80, "0000000001"};

        rst = 1'b0; data_in = '0; data_valid = 1'b0; hex_mode = 1'b0; line_sel = 1'b0;
        tick(2);
        chk("rst_data", int'(lcd_data), 0);
        chk("rst_rs", int'(lcd_rs), 0);
        chk("rst_e", int'(lcd_e), 0);
        chk("rst_ready", int'(data_ready), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rw_tied", int'(lcd_rw), 0);

        // Init sequence, with data_valid pulsed during INIT that must be ignored.
        rst = 1'b1;
        repeat (10) begin
            tick();
            data_valid = 1'b1; data_in = 10'($urandom);
        end
        data_valid = 1'b0;
        wait_init(300);
        chk("init_ready", int'(data_ready), 1);
        tick(2);
        chk("init_count", q.size(), 4);
        if (q.size() >= 4) begin
            chk("init_b0", int'(q[0]), 9'h038);
            chk("init_b1", int'(q[1]), 9'h00C);
            chk("init_b2", int'(q[2]), 9'h006);
            chk("init_b3", int'(q[3]), 9'h001);
        end
        n = id_rise_cyc - fall_cyc;
        total++;
        if (n < HOLD + CLRW || n > HOLD + CLRW + 3) begin
            bad++;
            $display("FAIL clr_gap: got %0d cycles want %0d..%0d", n, HOLD + CLRW, HOLD + CLRW + 3);
        end
        chk("init_accepts", acc_cnt, 0);

        for (int k = 0; k < 7; k++) run_vec(k, 1'b0);

        // Inputs toggled and valid raised mid-render: render must follow the latched value.
        run_vec(0, 1'b1);

        // Continuous valid: back-to-back renders, one accept per IDLE visit.
        wait_ready(300);
        q.delete(); a0 = acc_cnt; max_hi = 0;
        data_in = v[4].d; hex_mode = v[4].hex; line_sel = v[4].line; data_valid = 1'b1;
        n = 0;
        while (acc_cnt - a0 < 3 && n < 600) begin tick(); n++; end
        data_valid = 1'b0;
        wait_ready(400);
        chk("b2b_accepts", acc_cnt - a0, 3);
        naddr = 0;
        foreach (q[i]) if (q[i] == 9'h080 || q[i] == 9'h0C0) naddr++;
        chk("b2b_addr_cmds", naddr, 3);
        chk("b2b_bytes", q.size(), 12);
        chk("b2b_max_e_high", max_hi, PULSE);

        // Async reset while E is high, then init restarts from 0x38.
        data_in = v[1].d; hex_mode = v[1].hex; line_sel = v[1].line; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        n = 0;
        while (!lcd_e && n < 200) begin tick(); n++; end
        chk("mid_e_high", int'(lcd_e), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_e", int'(lcd_e), 0);
        chk("arst_data", int'(lcd_data), 0);
        chk("arst_rs", int'(lcd_rs), 0);
        chk("arst_ready", int'(data_ready), 0);
        chk("arst_init_done", int'(init_done), 0);
        tick(2);
        q.delete();
        rst = 1'b1;
        wait_init(300);
        tick(2);
        chk("reinit_count", q.size(), 4);
        if (q.size() > 0) chk("reinit_b0", int'(q[0]), 9'h038);

        chk("pulse_width_errs", bad_pw, 0);
        chk("data_stable_errs", bad_stab, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_value_display.md
Name: lcd_value_display

Overview:
- Parametrised successor to the team's binary-readout HD44780 LCD driver, for debug readout of processor registers.
- Runs an 8-bit-interface init sequence, then accepts values over a valid/ready handshake.
- Renders each accepted value as ASCII binary or hex digits on either display line.
- Generalises data width, bus-timing cycle counts, radix and line select; adds a proper E-pulse timing engine and back-pressure.

Parameters:
DATA_W, 10, value width; 1..16 (binary mode shows DATA_W chars, hex mode shows ceil(DATA_W/4) chars)
SETUP_CYC, 2, cycles RS/data held stable with E=0 before E rises (>=1)
PULSE_CYC, 12, cycles E held high (>=1)
HOLD_CYC, 2, cycles E=0 after E falls before the next byte (>=1)
CLR_WAIT, 80000, extra idle cycles after the clear-display command (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
data_in  in  DATA_W  value to display
data_valid  in  1  request to display data_in
hex_mode  in  1  0=binary digits, 1=hex digits; sampled with data_in
line_sel  in  1  0=line 1 (DDRAM 0x00), 1=line 2 (DDRAM 0x40); sampled with data_in
data_ready  out  1  high when a new value can be accepted
init_done  out  1  high once the init sequence has completed; stays high until reset
lcd_data  out  8  LCD DB7..DB0
lcd_rs  out  1  0=command, 1=data
lcd_rw  out  1  tied 0 (write only)
lcd_e  out  1  LCD enable strobe

Behaviour:
- Reset (rst=0, async): lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_e=0, data_ready=0, init_done=0; FSM -> INIT; byte index and digit counter cleared.
- Reset mid-transfer: E drops immediately; full init restarts after release.
- Byte transfer (one per command/char), driven by the byte writer:
  - SETUP_CYC cycles with E=0, then PULSE_CYC with E=1, then HOLD_CYC with E=0.
  - lcd_data and lcd_rs constant over the whole SETUP_CYC+PULSE_CYC+HOLD_CYC window.
  - A 1-cycle done pulse follows the last hold cycle.
- FSM states:
  - INIT: send in order 0x38 (8-bit, 2 lines), 0x0C (display on), 0x06 (entry inc), 0x01 (clear), then wait CLR_WAIT cycles.
  - IDLE: init_done=1, data_ready=1.
  - ADDR: send command 0x80 (line_sel=0) or 0xC0 (line_sel=1), using the latched line_sel.
  - CHAR: send digits MSB-first with RS=1.
  - Return to IDLE after the last char's done pulse.
- Handshake:
  - Accept only on data_valid && data_ready at a rising edge.
  - data_in, hex_mode and line_sel are latched on accept; later changes are ignored until the next accept.
  - data_ready falls the cycle after accept and is low for the whole ADDR+CHAR sequence.
  - data_valid while data_ready=0 (including during INIT) is ignored, not queued.
- Latency: the first lcd_e rise for the address command occurs SETUP_CYC+1 cycles after the accept edge.
- Digit encoding:
  - Binary: char = 0x30 + bit, bit index DATA_W-1 down to 0.
  - Hex: value zero-extended to 4*ceil(DATA_W/4) bits; nibble d<10 -> 0x30+d, d>=10 -> 0x37+d (uppercase A-F).
- No clear between values: a shorter hex render leaves stale chars to its right (documented behaviour, not a bug).
- Counters wide enough for CLR_WAIT with no wrap; cycle counters reload to 0 on each phase change.

Decomposition:
- Package lcd_pkg holds:
  - command constants: CMD_FUNC_8B2L=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY_INC=0x06, CMD_CLEAR=0x01, CMD_DDRAM_L1=0x80, CMD_DDRAM_L2=0xC0;
  - ASCII_ZERO=0x30;
  - FSM state enum.
- One sub-module, lcd_byte_writer:
  - inputs: start, rs, byte;
  - outputs: lcd_data, lcd_rs, lcd_e, done;
  - parameters: SETUP_CYC, PULSE_CYC, HOLD_CYC.
- Top holds the sequencing FSM, init ROM, CLR_WAIT counter and digit encoder.

Test Plan:
All tests use DATA_W=10, SETUP_CYC=1, PULSE_CYC=2, HOLD_CYC=1, CLR_WAIT=4.
1. Release rst, hold data_valid=0 -> lcd_data 0x38, 0x0C, 0x06, 0x01, each with RS=0 and one 2-cycle E pulse; 4-cycle gap after 0x01; then init_done=1 and data_ready=1.
2. After init, data_in=10'b1010000011, hex_mode=0, line_sel=0, 1-cycle valid -> command 0x80, then data bytes 0x31,0x30,0x31,0x30,0x30,0x30,0x30,0x30,0x31,0x31 with RS=1; data_ready low throughout, high after the last hold.
3. data_in=10'h2AF, hex_mode=1, line_sel=1 -> 0xC0, then 0x32, 0x41, 0x46; exactly 4 E pulses.
4. Toggle data_in and raise data_valid during INIT and mid-CHAR -> no extra accepts; the displayed chars match the value latched at the original accept.
5. Assert rst=0 asynchronously while lcd_e=1 -> lcd_e=0 before the next clock edge; all outputs at reset values; on release the init sequence restarts from 0x38.
6. Hold data_valid=1 continuously -> back-to-back renders; exactly one accept per IDLE visit; lcd_e never high for more than PULSE_CYC consecutive cycles.
